alu32_sched: RTL and testbench



---
 rtl/alu32_pkg.sv | 35 +++
 rtl/alu32_sched_if.sv | 33 +++
 rtl/alu32_sched_rr_arb2.sv | 22 ++
 rtl/alu32_sched.sv | 149 ++++++++++++++
 tb/tb_alu32_sched.sv | 389 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu32_pkg.sv
// Shared ALU select-code encodings and the select legality check used by the
// issue scheduler (and by anything else that decodes ALU select codes).
package alu32_pkg;

    // sel[5:3]: shift/rotate stage applied to the function result
    typedef enum logic [2:0] {
        SH_NONE = 3'b000,
        SH_L    = 3'b010,
        SH_R    = 3'b011,
        ROT_L   = 3'b100,
        ROT_R   = 3'b101,
        SH_RA   = 3'b111
    } shf_e;

    localparam int SEL_LOGIC_BIT = 2;

    // sel[1:0] with sel[2] = 0
    localparam logic [1:0] FN_ADD = 2'b00;
    localparam logic [1:0] FN_SUB = 2'b01;
    localparam logic [1:0] FN_INC = 2'b10;
    localparam logic [1:0] FN_DEC = 2'b11;
    // sel[1:0] with sel[2] = 1
    localparam logic [1:0] FN_AND = 2'b00;
    localparam logic [1:0] FN_OR  = 2'b01;
    localparam logic [1:0] FN_XOR = 2'b10;
    localparam logic [1:0] FN_NOT = 2'b11;

    function automatic logic sel_legal(input logic [5:0] sel);
        case (sel[5:3])
            SH_NONE, SH_L, SH_R, ROT_L, ROT_R, SH_RA: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu32_sched_if.sv
// Request and tagged-response channels between the front ends and the
// ALU issue scheduler.
interface alu32_sched_if #(
    parameter int W = 32
);
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [5:0]   req_sel0;
    logic [5:0]   req_sel1;
    logic         req_cin0;
    logic         req_cin1;
    logic [W-1:0] req_a0;
    logic [W-1:0] req_b0;
    logic [W-1:0] req_a1;
    logic [W-1:0] req_b1;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_y;
    logic         rsp_err;

    modport master (
        output req_valid, req_sel0, req_sel1, req_cin0, req_cin1,
               req_a0, req_b0, req_a1, req_b1, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_y, rsp_err
    );

    modport slave (
        input  req_valid, req_sel0, req_sel1, req_cin0, req_cin1,
               req_a0, req_b0, req_a1, req_b1, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_y, rsp_err
    );
endinterface

// File: rtl/alu32_sched_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins, prio breaks ties.
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       free_i,
    input  logic       prio_i,
    output logic [1:0] gnt_o,
    output logic       upd_o
);
    always_comb begin
        gnt_o = 2'b00;
        if (free_i) begin
            case (valid_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = prio_i ? 2'b10 : 2'b01;
                default: gnt_o = 2'b00;
            endcase
        end
    end

    assign upd_o = |gnt_o;
endmodule

// File: rtl/alu32_sched.sv
// Issue scheduler for the shared ALU: round-robin over two requesters, an
// issue stage that drives the ALU, and a write-back stage on a tagged channel.
module alu32_sched
    import alu32_pkg::*;
#(
    parameter int W  = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    alu32_sched_if.slave  bus,
    output logic [5:0]    alu_sel,
    output logic          alu_cin,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    input  logic [W-1:0]  alu_y,
    output logic [CW-1:0] gnt_cnt0,
    output logic [CW-1:0] gnt_cnt1
);
    logic          is_valid_q, is_valid_d;
    logic          is_id_q, is_id_d;
    logic          is_err_q, is_err_d;
    logic [5:0]    is_sel_q, is_sel_d;
    logic          is_cin_q, is_cin_d;
    logic [W-1:0]  is_a_q, is_a_d;
    logic [W-1:0]  is_b_q, is_b_d;
    logic          wb_valid_q, wb_valid_d;
    logic          wb_id_q, wb_id_d;
    logic          wb_err_q, wb_err_d;
    logic [W-1:0]  wb_y_q, wb_y_d;
    logic          prio_q, prio_d;
    logic [CW-1:0] cnt0_q, cnt0_d;
    logic [CW-1:0] cnt1_q, cnt1_d;

    logic          wb_free, is_adv, is_free;
    logic [1:0]    gnt;
    logic          upd, gnt_id;
    logic [5:0]    acc_sel;
    logic          acc_cin, acc_legal;
    logic [W-1:0]  acc_a, acc_b;

    assign wb_free = !wb_valid_q || bus.rsp_ready;
    assign is_adv  = is_valid_q && wb_free;
    // rst_n gating keeps req_ready low for the whole reset window
    assign is_free = (!is_valid_q || is_adv) && rst_n;

    rr_arb2 u_arb (
        .valid_i (bus.req_valid),
        .free_i  (is_free),
        .prio_i  (prio_q),
        .gnt_o   (gnt),
        .upd_o   (upd)
    );

    assign gnt_id    = gnt[1];
    assign acc_sel   = gnt_id ? bus.req_sel1 : bus.req_sel0;
    assign acc_cin   = gnt_id ? bus.req_cin1 : bus.req_cin0;
    assign acc_a     = gnt_id ? bus.req_a1   : bus.req_a0;
    assign acc_b     = gnt_id ? bus.req_b1   : bus.req_b0;
    assign acc_legal = sel_legal(acc_sel);

    always_comb begin
        is_valid_d = is_valid_q;
        is_id_d    = is_id_q;
        is_err_d   = is_err_q;
        is_sel_d   = is_sel_q;
        is_cin_d   = is_cin_q;
        is_a_d     = is_a_q;
        is_b_d     = is_b_q;
        wb_valid_d = wb_valid_q;
        wb_id_d    = wb_id_q;
        wb_err_d   = wb_err_q;
        wb_y_d     = wb_y_q;
        prio_d     = prio_q;
        cnt0_d     = cnt0_q;
        cnt1_d     = cnt1_q;

        if (upd) begin
            // A flagged op is parked as all-zero so the ALU never sees an illegal code
            is_valid_d = 1'b1;
            is_id_d    = gnt_id;
            is_err_d   = !acc_legal;
            is_sel_d   = acc_legal ? acc_sel : '0;
            is_cin_d   = acc_legal ? acc_cin : 1'b0;
            is_a_d     = acc_legal ? acc_a   : '0;
            is_b_d     = acc_legal ? acc_b   : '0;
            prio_d     = !gnt_id;
            if (gnt_id) cnt1_d = cnt1_q + CW'(1);
            else        cnt0_d = cnt0_q + CW'(1);
        end else if (is_adv) begin
            is_valid_d = 1'b0;
        end

        if (is_adv) begin
            wb_valid_d = 1'b1;
            wb_id_d    = is_id_q;
            wb_err_d   = is_err_q;
            wb_y_d     = is_err_q ? '0 : alu_y;
        end else if (wb_free) begin
            wb_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_valid_q <= 1'b0;
            is_id_q    <= 1'b0;
            is_err_q   <= 1'b0;
            is_sel_q   <= '0;
            is_cin_q   <= 1'b0;
            is_a_q     <= '0;
            is_b_q     <= '0;
            wb_valid_q <= 1'b0;
            wb_id_q    <= 1'b0;
            wb_err_q   <= 1'b0;
            wb_y_q     <= '0;
            prio_q     <= 1'b0;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
        end else begin
            is_valid_q <= is_valid_d;
            is_id_q    <= is_id_d;
            is_err_q   <= is_err_d;
            is_sel_q   <= is_sel_d;
            is_cin_q   <= is_cin_d;
            is_a_q     <= is_a_d;
            is_b_q     <= is_b_d;
            wb_valid_q <= wb_valid_d;
            wb_id_q    <= wb_id_d;
            wb_err_q   <= wb_err_d;
            wb_y_q     <= wb_y_d;
            prio_q     <= prio_d;
            cnt0_q     <= cnt0_d;
            cnt1_q     <= cnt1_d;
        end
    end

    assign bus.req_ready = gnt;
    assign alu_sel       = is_sel_q;
    assign alu_cin       = is_cin_q;
    assign alu_a         = is_a_q;
    assign alu_b         = is_b_q;
    assign bus.rsp_valid = wb_valid_q;
    assign bus.rsp_id    = wb_id_q;
    assign bus.rsp_err   = wb_err_q;
    assign bus.rsp_y     = wb_y_q;
    assign gnt_cnt0      = cnt0_q;
    assign gnt_cnt1      = cnt1_q;
endmodule

// File: tb/tb_alu32_sched.sv
// Bench for alu32_sched: a stub ALU, an acceptance/response scoreboard and one
// task per scenario.
module tb_alu32_sched;
    import alu32_pkg::*;

    typedef struct packed {
        logic        id;
        logic        err;
        logic [31:0] y;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  alu_sel;
    logic        alu_cin;
    logic [31:0] alu_a, alu_b, alu_y;
    logic [3:0]  gnt_cnt0, gnt_cnt1;
    int          errors = 0;
    int          checks = 0;
    rsp_t        exp_q[$];
    logic        gnt_log[$];
    rsp_t        mon_e, mon_g;
    logic [5:0]  mon_s;
    logic        mon_c, mon_legal;
    logic [31:0] mon_a, mon_b;

    alu32_sched_if #(.W(32)) bus ();

    alu32_sched #(.W(32), .CW(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .alu_sel  (alu_sel),
        .alu_cin  (alu_cin),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_y    (alu_y),
        .gnt_cnt0 (gnt_cnt0),
        .gnt_cnt1 (gnt_cnt1)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [5:0] s, input logic c,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic [4:0]  sh;
        sh = b[4:0];
        if (s[SEL_LOGIC_BIT]) begin
            case (s[1:0])
                FN_AND:  r = a & b;
                FN_OR:   r = a | b;
                FN_XOR:  r = a ^ b;
                default: r = ~a;
            endcase
        end else begin
            case (s[1:0])
                FN_ADD:  r = a + b + {31'b0, c};
                FN_SUB:  r = a - b - {31'b0, c};
                FN_INC:  r = a + 32'd1;
                default: r = a - 32'd1;
            endcase
        end
        case (s[5:3])
            SH_L:    r = r << sh;
            SH_R:    r = r >> sh;
            ROT_L:   r = (r << sh) | (r >> (6'd32 - {1'b0, sh}));
            ROT_R:   r = (r >> sh) | (r << (6'd32 - {1'b0, sh}));
            SH_RA:   r = $signed(r) >>> sh;
            default: r = r;
        endcase
        return r;
    endfunction

    assign alu_y = alu_ref(alu_sel, alu_cin, alu_a, alu_b);

    // Scoreboard: responses are checked against the queue, then acceptances pushed
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            mon_g = '{bus.rsp_id, bus.rsp_err, bus.rsp_y};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got=%h required=no response", mon_g);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_g !== mon_e) begin
                    errors++;
                    $display("FAIL sb_rsp got=%h required=%h", mon_g, mon_e);
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (rst_n && bus.req_ready[i] && bus.req_valid[i]) begin
                mon_s     = (i == 1) ? bus.req_sel1 : bus.req_sel0;
                mon_c     = (i == 1) ? bus.req_cin1 : bus.req_cin0;
                mon_a     = (i == 1) ? bus.req_a1 : bus.req_a0;
                mon_b     = (i == 1) ? bus.req_b1 : bus.req_b0;
                mon_legal = (mon_s[5:3] != 3'b001) && (mon_s[5:3] != 3'b110);
                mon_e = '{(i == 1), !mon_legal,
                          mon_legal ? alu_ref(mon_s, mon_c, mon_a, mon_b) : 32'd0};
                exp_q.push_back(mon_e);
                gnt_log.push_back(i == 1);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_valid = 2'b00;
        cyc();
        cyc();
        exp_q.delete();
        gnt_log.delete();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = 2'b11;
        bus.rsp_ready = 1'b1;
        bus.req_sel0 = 6'b000000; bus.req_sel1 = 6'b000000;
        bus.req_cin0 = 1'b1;      bus.req_cin1 = 1'b1;
        bus.req_a0 = 32'd9; bus.req_b0 = 32'd9; bus.req_a1 = 32'd9; bus.req_b1 = 32'd9;
        cyc();
        cyc();
        checks++;
        if (bus.req_ready !== 2'b00) begin
            errors++; $display("FAIL reset_ready got=%b required=00", bus.req_ready);
        end
        checks++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_y} !== 35'd0) begin
            errors++; $display("FAIL reset_rsp got=%b%b%b %h required=000 0",
                               bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_y);
        end
        checks++;
        if ({alu_sel, alu_cin, alu_a, alu_b} !== 71'd0) begin
            errors++; $display("FAIL reset_alu got=%h %b %h %h required=0",
                               alu_sel, alu_cin, alu_a, alu_b);
        end
        checks++;
        if ({gnt_cnt0, gnt_cnt1} !== 8'd0) begin
            errors++; $display("FAIL reset_cnt got=%0d/%0d required=0/0", gnt_cnt0, gnt_cnt1);
        end
        bus.req_valid = 2'b00;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        bus.req_sel0 = 6'b000000; bus.req_cin0 = 1'b0;
        bus.req_a0 = 32'd5;       bus.req_b0 = 32'd7;
        bus.req_valid = 2'b01;
        #1;
        checks++;
        if (bus.req_ready !== 2'b01) begin
            errors++; $display("FAIL single_ready got=%b required=01", bus.req_ready);
        end
        cyc();
        bus.req_valid = 2'b00;
        checks++;
        if ({alu_sel, alu_a, alu_b, bus.rsp_valid} !== {6'd0, 32'd5, 32'd7, 1'b0}) begin
            errors++; $display("FAIL single_issue got=%h %0d %0d v=%b required=00 5 7 v=0",
                               alu_sel, alu_a, alu_b, bus.rsp_valid);
        end
        cyc();
        checks++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_y} !== {3'b100, 32'd12}) begin
            errors++; $display("FAIL single_rsp got=v%b id%b e%b y%0d required=v1 id0 e0 y12",
                               bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_y);
        end
        checks++;
        if (gnt_cnt0 !== 4'd1) begin
            errors++; $display("FAIL single_cnt got=%0d required=1", gnt_cnt0);
        end
        cyc();
        checks++;
        if (bus.rsp_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++; $display("FAIL single_done got=v%b pending=%0d required=v0 pending=0",
                               bus.rsp_valid, exp_q.size());
        end
    endtask

    task automatic test_contention();
        do_reset();
        bus.rsp_ready = 1'b1;
        bus.req_sel0 = 6'b010_000;  // shift left, add
        bus.req_sel1 = 6'b101_110;  // rotate right, xor
        bus.req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            bus.req_a0 = 32'd10 * k + 32'd1; bus.req_b0 = k;
            bus.req_a1 = 32'h100 + k;        bus.req_b1 = 32'd3;
            bus.req_cin0 = k[0];             bus.req_cin1 = k[1];
            cyc();
        end
        bus.req_valid = 2'b00;
        checks++;
        if (gnt_log.size() != 6) begin
            errors++; $display("FAIL cont_ngrants got=%0d required=6", gnt_log.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (gnt_log[k] !== k[0]) begin
                    errors++; $display("FAIL cont_order[%0d] got=%b required=%b", k, gnt_log[k], k[0]);
                end
            end
        end
        checks++;
        if (gnt_cnt0 !== 4'd3 || gnt_cnt1 !== 4'd3) begin
            errors++; $display("FAIL cont_cnt got=%0d/%0d required=3/3", gnt_cnt0, gnt_cnt1);
        end
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) cyc();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL cont_drain got=%0d pending required=0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        int          sent;
        logic        acc;
        logic [31:0] a_hold, y_hold;
        sent = 0;
        bus.req_sel0 = 6'b011_001;  // shift right, sub
        for (int c = 0; c < 30 && sent < 4; c++) begin
            bus.rsp_ready = (c >= 5);
            bus.req_valid = 2'b01;
            bus.req_a0 = 32'd1000 * (sent + 1);
            bus.req_b0 = sent + 2;
            bus.req_cin0 = sent[0];
            @(negedge clk);
            if (c == 2) begin
                a_hold = alu_a;
                y_hold = bus.rsp_y;
                checks++;
                if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 1'b1 || alu_a !== 32'd2000) begin
                    errors++; $display("FAIL bp_full got=rdy%b v%b a%0d required=rdy00 v1 a2000",
                                       bus.req_ready, bus.rsp_valid, alu_a);
                end
            end
            if (c == 4) begin
                checks++;
                if (alu_a !== a_hold || bus.rsp_y !== y_hold || bus.rsp_valid !== 1'b1
                    || bus.req_ready !== 2'b00) begin
                    errors++; $display("FAIL bp_stable got=a%0d y%h v%b rdy%b required=a%0d y%h v1 rdy00",
                                       alu_a, bus.rsp_y, bus.rsp_valid, bus.req_ready, a_hold, y_hold);
                end
            end
            acc = bus.req_ready[0];
            @(posedge clk);
            #1;
            if (acc) sent++;
        end
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b1;
        checks++;
        if (sent != 4) begin
            errors++; $display("FAIL bp_sent got=%0d required=4", sent);
        end
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) cyc();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL bp_drain got=%0d pending required=0", exp_q.size());
        end
    endtask

    task automatic test_illegal();
        bus.rsp_ready = 1'b1;
        bus.req_sel1 = 6'b001000; bus.req_cin1 = 1'b1;
        bus.req_a1 = 32'hDEAD_BEEF; bus.req_b1 = 32'h1234;
        bus.req_valid = 2'b10;
        #1;
        checks++;
        if (bus.req_ready !== 2'b10) begin
            errors++; $display("FAIL ill_ready got=%b required=10", bus.req_ready);
        end
        cyc();
        bus.req_valid = 2'b00;
        checks++;
        if ({alu_sel, alu_cin, alu_a, alu_b} !== 71'd0) begin
            errors++; $display("FAIL ill_alu got=%h %b %h %h required=0", alu_sel, alu_cin, alu_a, alu_b);
        end
        cyc();
        checks++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_y} !== {3'b111, 32'd0}) begin
            errors++; $display("FAIL ill_rsp got=v%b id%b e%b y%h required=v1 id1 e1 y0",
                               bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_y);
        end
        bus.req_sel1 = 6'b000_101;  // or
        bus.req_a1 = 32'h0000_00F0; bus.req_b1 = 32'h0000_000F;
        bus.req_valid = 2'b10;
        cyc();
        bus.req_valid = 2'b00;
        cyc();
        checks++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_y} !== {3'b110, 32'hFF}) begin
            errors++; $display("FAIL ill_next got=v%b id%b e%b y%h required=v1 id1 e0 y000000ff",
                               bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_y);
        end
        cyc();
    endtask

    task automatic test_reset_midflight();
        bus.rsp_ready = 1'b0;
        bus.req_sel0 = 6'b000000; bus.req_cin0 = 1'b0;
        bus.req_a0 = 32'd11; bus.req_b0 = 32'd22;
        bus.req_valid = 2'b01;
        cyc();
        bus.req_a0 = 32'd33;
        cyc();
        bus.req_valid = 2'b00;
        checks++;
        if (bus.rsp_valid !== 1'b1 || alu_a !== 32'd33) begin
            errors++; $display("FAIL mid_fill got=v%b a%0d required=v1 a33", bus.rsp_valid, alu_a);
        end
        #2;
        rst_n = 1'b0;
        bus.req_valid = 2'b11;
        #1;
        exp_q.delete();
        checks++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_y, alu_sel, alu_cin, alu_a, alu_b,
             gnt_cnt0, gnt_cnt1, bus.req_ready} !== 116'd0) begin
            errors++; $display("FAIL mid_clear got=v%b y%h a%h cnt%0d/%0d rdy%b required=all 0",
                               bus.rsp_valid, bus.rsp_y, alu_a, gnt_cnt0, gnt_cnt1, bus.req_ready);
        end
        bus.req_valid = 2'b00;
        cyc();
        cyc();
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        repeat (5) cyc();
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++; $display("FAIL mid_norsp got=v%b required=v0", bus.rsp_valid);
        end
    endtask

    task automatic test_wrap();
        int   sent;
        logic acc;
        sent = 0;
        do_reset();
        bus.rsp_ready = 1'b1;
        bus.req_sel0 = 6'b000_010;  // inc
        for (int c = 0; c < 40 && sent < 17; c++) begin
            bus.req_valid = 2'b01;
            bus.req_a0 = 32'd50 + sent;
            @(negedge clk);
            acc = bus.req_ready[0];
            @(posedge clk);
            #1;
            if (acc) sent++;
        end
        bus.req_valid = 2'b00;
        checks++;
        if (sent != 17 || gnt_cnt0 !== 4'd1 || gnt_cnt1 !== 4'd0) begin
            errors++; $display("FAIL wrap_cnt got=sent%0d c0=%0d c1=%0d required=sent17 c0=1 c1=0",
                               sent, gnt_cnt0, gnt_cnt1);
        end
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) cyc();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL wrap_drain got=%0d pending required=0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_illegal();
        test_reset_midflight();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=completion");
        $fatal(1, "bench did not complete");
    end
endmodule
